// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - six-line interrupt controller with edge/level modes, enable masking and priority service
// Optional feature macro: INT_CTRL_SYNC_EN adds a 2-flop synchronizer on every irq_in line.
module int_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  irq_in,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        int_ack,
  output logic [5:0]  HWInt
);

  typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} state_t;
  localparam logic [2:0] ID_NONE = 3'd7;

  state_t     state;
  logic [2:0] id;
  logic [5:0] mode;
  logic [5:0] enable;
  logic [5:0] pending;
  logic [5:0] prev;
  logic [5:0] s;

`ifdef INT_CTRL_SYNC_EN
  logic [5:0] sync_q1;
  logic [5:0] sync_q2;

  // two-stage synchronizer for the asynchronous device lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end
  assign s = sync_q2;
`else
  assign s = irq_in;
`endif

  logic       wr;
  logic       wr_mode;
  logic       wr_enable;
  logic       wr_pending;
  logic       eoi;
  logic       ack_take;
  logic [2:0] ack_id;
  logic [5:0] ack_onehot;
  logic [5:0] service_mask;
  logic [5:0] clr;
  logic [5:0] rise;
  logic [5:0] pending_next;
  logic       unused_wdata;

  assign wr         = sel & we;
  assign wr_mode    = wr & (addr == 2'd0);
  assign wr_enable  = wr & (addr == 2'd1);
  assign wr_pending = wr & (addr == 2'd2);
  assign eoi        = wr & (addr == 2'd3) & (state == SERVICE);
  assign unused_wdata = ^wdata[31:6];

  // while servicing, only lines of strictly higher priority (lower index) may interrupt
  always_comb begin
    service_mask = 6'h3F;
    if (state == SERVICE) begin
      for (int i = 0; i < 6; i++) begin
        service_mask[i] = (3'(i) < id);
      end
    end
  end

  assign HWInt = pending & enable & service_mask;

  // priority pick: lowest set index wins
  always_comb begin
    ack_id     = 3'd0;
    ack_onehot = '0;
    for (int i = 5; i >= 0; i--) begin
      if (HWInt[i]) begin
        ack_id        = 3'(i);
        ack_onehot    = '0;
        ack_onehot[i] = 1'b1;
      end
    end
  end

  assign ack_take = int_ack & (state == IDLE) & (|HWInt);

  // edge lines latch rises (a rise beats any clear), level lines mirror the sampled line
  always_comb begin
    clr          = ({6{wr_pending}} & wdata[5:0]) | (ack_take ? ack_onehot : 6'b0);
    rise         = s & ~prev;
    pending_next = (mode & (rise | (pending & ~clr))) | (~mode & s);
  end

  // configuration registers, edge history and pending capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode    <= '0;
      enable  <= '0;
      pending <= '0;
      prev    <= '0;
    end else begin
      if (wr_mode)   mode   <= wdata[5:0];
      if (wr_enable) enable <= wdata[5:0];
      pending <= pending_next;
      prev    <= s;
    end
  end

  // service state machine: ack enters SERVICE, EOI returns to IDLE; no nesting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      id    <= ID_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (ack_take) begin
            state <= SERVICE;
            id    <= ack_id;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state <= IDLE;
            id    <= ID_NONE;
          end
        end
        default: begin
          state <= IDLE;
          id    <= ID_NONE;
        end
      endcase
    end
  end

  // register read mux, unused bits read as zero
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = {26'b0, mode};
      2'd1: rdata = {26'b0, enable};
      2'd2: rdata = {26'b0, pending};
      2'd3: rdata = {28'b0, (state == SERVICE), id};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl: directed vector table, random model compare, reset corner
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_ack;
  logic [5:0]  HWInt;

  int checks = 0;
  int errors = 0;

  int_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .int_ack(int_ack), .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  irq;
    logic        ack;
    logic [5:0]  exp_hw;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s_, logic w_, logic [1:0] a_, logic [31:0] d_,
                              logic [5:0] i_, logic k_, logic [5:0] h_, logic [31:0] r_);
    vec_t v;
    v.sel = s_; v.we = w_; v.addr = a_; v.wdata = d_;
    v.irq = i_; v.ack = k_; v.exp_hw = h_; v.exp_rd = r_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic s_, input logic w_, input logic [1:0] a_,
                     input logic [31:0] d_, input logic [5:0] i_, input logic k_);
    sel = s_; we = w_; addr = a_; wdata = d_; irq_in = i_; int_ack = k_;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  bit [5:0] m_mode, m_en, m_pend, m_prev;
  bit [5:0] m_pipe[2];
  bit       m_svc;
  int       m_id;

  task automatic model_reset();
    m_mode = 0; m_en = 0; m_pend = 0; m_prev = 0;
    m_pipe[0] = 0; m_pipe[1] = 0;
    m_svc = 0; m_id = 7;
  endtask

  function automatic bit [5:0] model_hw();
    bit [5:0] r = 0;
    for (int i = 0; i < 6; i++)
      if (m_pend[i] && m_en[i] && (!m_svc || i < m_id)) r[i] = 1;
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return {26'b0, m_mode};
      2'd1: return {26'b0, m_en};
      2'd2: return {26'b0, m_pend};
      default: return {28'b0, m_svc, 3'(m_id)};
    endcase
  endfunction

  task automatic model_step(input bit s_, input bit w_, input bit [1:0] a_,
                            input bit [31:0] d_, input bit [5:0] irq, input bit k_);
    bit [5:0] line = (LAT == 2) ? m_pipe[1] : irq;
    bit [5:0] hw = model_hw();
    bit       write = s_ && w_;
    bit       take = k_ && !m_svc && (hw != 0);
    int       winner = -1;
    bit [5:0] np;
    for (int i = 0; i < 6; i++) if (winner < 0 && hw[i]) winner = i;
    for (int i = 0; i < 6; i++) begin
      if (!m_mode[i]) np[i] = line[i];
      else if (line[i] && !m_prev[i]) np[i] = 1;
      else if ((write && a_ == 2 && d_[i]) || (take && i == winner)) np[i] = 0;
      else np[i] = m_pend[i];
    end
    if (take) begin m_svc = 1; m_id = winner; end
    else if (m_svc && write && a_ == 3) begin m_svc = 0; m_id = 7; end
    if (write && a_ == 0) m_mode = d_[5:0];
    if (write && a_ == 1) m_en = d_[5:0];
    m_pend = np;
    m_prev = line;
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = irq;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sel = 0; we = 0; addr = 0; wdata = 0; irq_in = 0; int_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [5:0] rirq;
    logic       rs, rw, rk;
    logic [1:0] ra;
    logic [31:0] rd;

    do_reset();
    chk("reset_hwint", {26'b0, HWInt}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk($sformatf("reset_rdata_a%0d", a), rdata, (a == 3) ? 32'h7 : 32'h0);
    end

    //          sel we addr wdata  irq   ack  hw     rd
    tbl.push_back(mk(1, 1, 0, 32'h01, 6'h00, 0, 6'h00, 32'h01));
    tbl.push_back(mk(1, 1, 1, 32'h01, 6'h00, 0, 6'h00, 32'h01));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h01, 0, 6'h01, 32'h01));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h00, 0, 6'h01, 32'h01));
    tbl.push_back(mk(1, 1, 2, 32'h01, 6'h00, 0, 6'h00, 32'h00));
    tbl.push_back(mk(1, 1, 0, 32'h3F, 6'h00, 0, 6'h00, 32'h3F));
    tbl.push_back(mk(1, 1, 1, 32'h3F, 6'h00, 0, 6'h00, 32'h3F));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h14, 0, 6'h14, 32'h14));
    tbl.push_back(mk(0, 0, 3, 32'h00, 6'h14, 1, 6'h00, 32'h0A));
    tbl.push_back(mk(0, 0, 3, 32'h00, 6'h16, 0, 6'h02, 32'h0A));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h16, 1, 6'h02, 32'h12));
    tbl.push_back(mk(1, 1, 2, 32'h02, 6'h16, 0, 6'h00, 32'h10));
    tbl.push_back(mk(1, 1, 3, 32'h00, 6'h16, 0, 6'h10, 32'h07));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h08, 0, 6'h18, 32'h18));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h00, 0, 6'h18, 32'h18));
    tbl.push_back(mk(1, 1, 2, 32'h08, 6'h08, 0, 6'h18, 32'h18));
    tbl.push_back(mk(1, 1, 2, 32'h18, 6'h08, 0, 6'h00, 32'h00));
    tbl.push_back(mk(0, 0, 3, 32'h00, 6'h08, 1, 6'h00, 32'h07));
    tbl.push_back(mk(1, 1, 0, 32'h00, 6'h08, 0, 6'h00, 32'h00));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h08, 0, 6'h08, 32'h08));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h00, 0, 6'h00, 32'h00));
    tbl.push_back(mk(0, 0, 2, 32'h00, 6'h21, 0, 6'h21, 32'h21));
    tbl.push_back(mk(0, 0, 3, 32'h00, 6'h21, 1, 6'h00, 32'h08));
    tbl.push_back(mk(1, 1, 3, 32'h00, 6'h00, 1, 6'h00, 32'h07));

    for (int v = 0; v < tbl.size(); v++) begin
      // let the new line level reach the sampling point before the step's own edge
      for (int d = 0; d < LAT; d++) cyc(0, 0, tbl[v].addr, 0, tbl[v].irq, 0);
      cyc(tbl[v].sel, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].irq, tbl[v].ack);
      chk($sformatf("vec%0d_hwint", v), {26'b0, HWInt}, {26'b0, tbl[v].exp_hw});
      chk($sformatf("vec%0d_rdata", v), rdata, tbl[v].exp_rd);
    end

    do_reset();
    rirq = 0;
    for (int n = 0; n < 3000; n++) begin
      rs = ($urandom % 4) == 0;
      rw = $urandom % 2;
      ra = 2'($urandom % 4);
      rd = $urandom;
      if (($urandom % 3) == 0) rirq = rirq ^ 6'($urandom);
      rk = ($urandom % 5) == 0;
      model_step(rs, rw, ra, rd, rirq, rk);
      cyc(rs, rw, ra, rd, rirq, rk);
      chk($sformatf("rand%0d_hwint", n), {26'b0, HWInt}, {26'b0, model_hw()});
      chk($sformatf("rand%0d_rdata", n), rdata, model_rd(ra));
    end

    do_reset();
    cyc(1, 1, 0, 32'h3F, 6'h00, 0);
    cyc(1, 1, 1, 32'h3F, 6'h00, 0);
    for (int d = 0; d <= LAT; d++) cyc(0, 0, 3, 0, 6'h04, 0);
    cyc(0, 0, 3, 0, 6'h04, 1);
    chk("svc_status", rdata, 32'h0A);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_hwint", {26'b0, HWInt}, 32'h0);
    chk("rst_mid_status", rdata, 32'h07);
    addr = 2'd1;
    #1;
    chk("rst_mid_enable", rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(0, 0, 3, 0, 6'h04, 1);
    chk("resume_status", rdata, 32'h07);
    chk("resume_hwint", {26'b0, HWInt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
